// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
//   Elastic pipeline register with a 2-entry skid buffer. It carries a
//   WIDTH-bit payload across a valid/ready handshake at full throughput.
//   in_ready comes straight from a flop, so there is no combinational path
//   from out_ready back to in_ready.
//   The main register always feeds out_data. The skid register catches the
//   one beat that arrives while the head is stalled.
//   Reset is synchronous and active-low. A synchronous flush squashes both
//   entries and drops any same-cycle handshake.
// -----------------------------------------------------------------------------
module elastic_pipe_reg #(
   parameter int WIDTH      = 177,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // Each state encoding equals the number of held entries.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;

   logic             accept_s;
   logic             pop_s;

   logic             in_ready_r;
   logic             out_valid_r;
   logic [1:0]       occupancy_r;
   logic             in_ready_nxt_s;
   logic             out_valid_nxt_s;
   logic [1:0]       occupancy_nxt_s;

   logic             main_ld_in_s;
   logic             main_ld_skid_s;
   logic             skid_ld_s;

   logic [WIDTH-1:0] main_r;
   logic [WIDTH-1:0] skid_r;

   // The handshakes use only registered status, so upstream and downstream
   // both see the same stable values for the whole cycle.
   assign accept_s = in_valid & in_ready_r;
   assign pop_s    = out_valid_r & out_ready;

   // State register plus registered status outputs; reset forces EMPTY and drops in_ready.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         occupancy_r <= 2'd0;
      end else begin
         state_r     <= state_nxt_s;
         in_ready_r  <= in_ready_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         occupancy_r <= occupancy_nxt_s;
      end
   end

   // Next-state logic: flush wins over any handshake and empties the buffer.
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_nxt_s = ST_ONE;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && !pop_s) begin
                  state_nxt_s = ST_TWO;
               end else if (!accept_s && pop_s) begin
                  state_nxt_s = ST_EMPTY;
               end else begin
                  state_nxt_s = ST_ONE;
               end
            end
            ST_TWO: begin
               if (pop_s) begin
                  state_nxt_s = ST_ONE;
               end else begin
                  state_nxt_s = ST_TWO;
               end
            end
            default: begin
               state_nxt_s = ST_EMPTY;
            end
         endcase
      end
   end

   // Output/datapath decode: next-cycle status values and register load enables.
   always_comb begin
      in_ready_nxt_s  = (state_nxt_s != ST_TWO);
      out_valid_nxt_s = (state_nxt_s != ST_EMPTY);
      main_ld_in_s    = 1'b0;
      main_ld_skid_s  = 1'b0;
      skid_ld_s       = 1'b0;

      case (state_nxt_s)
         ST_EMPTY: occupancy_nxt_s = 2'd0;
         ST_ONE:   occupancy_nxt_s = 2'd1;
         ST_TWO:   occupancy_nxt_s = 2'd2;
         default:  occupancy_nxt_s = 2'd0;
      endcase

      if (flush) begin
         main_ld_in_s   = 1'b0;
         main_ld_skid_s = 1'b0;
         skid_ld_s      = 1'b0;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               main_ld_in_s = accept_s;
            end
            ST_ONE: begin
               // If the head pops in the same cycle, the new beat goes straight
               // to the head; otherwise it overflows into skid.
               main_ld_in_s = accept_s & pop_s;
               skid_ld_s    = accept_s & ~pop_s;
            end
            ST_TWO: begin
               main_ld_skid_s = pop_s;
            end
            default: begin
               main_ld_in_s   = 1'b0;
               main_ld_skid_s = 1'b0;
               skid_ld_s      = 1'b0;
            end
         endcase
      end
   end

   // Payload registers: optionally cleared on reset/flush, otherwise loaded per decode.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         if (CLEAR_DATA) begin
            main_r <= {WIDTH{1'b0}};
            skid_r <= {WIDTH{1'b0}};
         end else begin
            main_r <= main_r;
            skid_r <= skid_r;
         end
      end else begin
         if (main_ld_in_s) begin
            main_r <= in_data;
         end else if (main_ld_skid_s) begin
            main_r <= skid_r;
         end else begin
            main_r <= main_r;
         end

         if (skid_ld_s) begin
            skid_r <= in_data;
         end else begin
            skid_r <= skid_r;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign occupancy = occupancy_r;
   assign out_data  = main_r;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_reg
//   dut_a is WIDTH=8 with CLEAR_DATA=1. It runs a table of directed vectors:
//   reset, streaming, skid fill/drain, flush and mid-stream reset.
//   dut_b is WIDTH=177 with CLEAR_DATA=0. It runs a reset-retention sequence,
//   then random traffic checked against a queue scoreboard.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_reg;

   logic         clk;

   logic         ra, fa, iva, ora;
   logic [7:0]   ida;
   logic         ira, ova;
   logic [7:0]   oda;
   logic [1:0]   occa;

   logic         rb, fb, ivb, orb;
   logic [176:0] idb;
   logic         irb, ovb;
   logic [176:0] odb;
   logic [1:0]   occb;

   int           n_vec;
   int           n_err;

   typedef struct {
      logic       rst;
      logic       fl;
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_od;
      logic [1:0] e_occ;
      logic       ck_od;
   } vec_t;

   vec_t         tbl[$];
   logic [176:0] sb[$];

   elastic_pipe_reg #(.WIDTH(8), .CLEAR_DATA(1'b1)) dut_a (
      .clk(clk), .reset(ra), .flush(fa), .in_valid(iva), .in_ready(ira),
      .in_data(ida), .out_valid(ova), .out_ready(ora), .out_data(oda),
      .occupancy(occa)
   );

   elastic_pipe_reg #(.WIDTH(177), .CLEAR_DATA(1'b0)) dut_b (
      .clk(clk), .reset(rb), .flush(fb), .in_valid(ivb), .in_ready(irb),
      .in_data(idb), .out_valid(ovb), .out_ready(orb), .out_data(odb),
      .occupancy(occb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [176:0] act, input logic [176:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic rst, input logic fl, input logic iv, input logic [7:0] id,
                      input logic ordy, input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                      input logic [1:0] e_occ, input logic ck_od);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.ck_od = ck_od;
      tbl.push_back(v);
   endtask

   function automatic logic [176:0] rnd177();
      logic [191:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[176:0];
   endfunction

   // One random-traffic cycle on dut_b, checked against the scoreboard.
   task automatic step_b(input logic iv, input logic [176:0] d, input logic ordy);
      logic         acc, pop, stall;
      logic [176:0] held;
      ivb = iv; idb = d; orb = ordy;
      #3;
      acc   = ivb & irb;
      pop   = ovb & orb;
      stall = ovb & ~orb;
      held  = odb;
      if (pop) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_empty: got pop expected no data at %0t", $time);
         end else begin
            chk("order", odb, sb[0]);
         end
      end
      @(posedge clk);
      #1;
      if (pop && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back(d);
      chk("rnd_occ", 177'(occb), 177'(sb.size()));
      chk("rnd_ov", 177'(ovb), 177'(sb.size() != 0));
      chk("rnd_ir", 177'(irb), 177'(sb.size() < 2));
      if (stall) chk("stable", odb, held);
   endtask

   // Apply one directed cycle to dut_b and check its status afterwards.
   task automatic cyc_b(input logic rst, input logic iv, input logic [176:0] d, input logic ordy,
                        input logic e_ir, input logic e_ov, input logic [1:0] e_occ);
      rb = rst; fb = 1'b0; ivb = iv; idb = d; orb = ordy;
      @(posedge clk);
      #1;
      chk("b_ir", 177'(irb), 177'(e_ir));
      chk("b_ov", 177'(ovb), 177'(e_ov));
      chk("b_occ", 177'(occb), 177'(e_occ));
   endtask

   initial begin
      logic [176:0] x1, x2, x3;
      n_vec = 0;
      n_err = 0;

      // Test 1: hold reset for two cycles, then release.
      add(0,0,0,8'h00,0, 0,0,8'h00,2'd0,1);
      add(0,0,0,8'h00,0, 0,0,8'h00,2'd0,1);
      add(1,0,0,8'h00,0, 1,0,8'h00,2'd0,1);
      // Test 2: stream 0x01..0x10 with out_ready held high.
      for (int k = 1; k <= 16; k++) add(1,0,1,8'(k),1, 1,1,8'(k),2'd1,1);
      add(1,0,0,8'h00,1, 1,0,8'h10,2'd0,0);
      // Test 3: fill the skid under backpressure, then drain in order.
      add(1,0,1,8'hA1,0, 1,1,8'hA1,2'd1,1);
      add(1,0,1,8'hA2,0, 0,1,8'hA1,2'd2,1);
      add(1,0,1,8'hA3,0, 0,1,8'hA1,2'd2,1);
      add(1,0,1,8'hA3,1, 1,1,8'hA2,2'd1,1);
      add(1,0,1,8'hA3,1, 1,1,8'hA3,2'd1,1);
      add(1,0,0,8'h00,1, 1,0,8'hA3,2'd0,0);
      // Test 4: flush while holding two entries; 0x88 is the next output.
      add(1,0,1,8'h55,0, 1,1,8'h55,2'd1,1);
      add(1,0,1,8'h66,0, 0,1,8'h55,2'd2,1);
      add(1,1,1,8'h77,0, 1,0,8'h00,2'd0,1);
      add(1,0,1,8'h88,0, 1,1,8'h88,2'd1,1);
      add(1,0,0,8'h00,1, 1,0,8'h88,2'd0,0);
      // Flush in ONE: the same-cycle accept and pop are both discarded.
      add(1,0,1,8'h99,0, 1,1,8'h99,2'd1,1);
      add(1,1,1,8'hAA,1, 1,0,8'h00,2'd0,1);
      add(1,0,1,8'h88,1, 1,1,8'h88,2'd1,1);
      add(1,0,0,8'h00,1, 1,0,8'h88,2'd0,0);
      // Reset mid-stream in TWO; the first accept after release enters main.
      add(1,0,1,8'h11,0, 1,1,8'h11,2'd1,1);
      add(1,0,1,8'h22,0, 0,1,8'h11,2'd2,1);
      add(0,0,1,8'h33,1, 0,0,8'h00,2'd0,1);
      add(1,0,0,8'h00,1, 1,0,8'h00,2'd0,1);
      add(1,0,1,8'h44,0, 1,1,8'h44,2'd1,1);
      add(1,0,0,8'h00,1, 1,0,8'h44,2'd0,0);

      rb = 1'b0; fb = 1'b0; ivb = 1'b0; idb = 177'd0; orb = 1'b0;

      foreach (tbl[i]) begin
         ra = tbl[i].rst; fa = tbl[i].fl; iva = tbl[i].iv; ida = tbl[i].id; ora = tbl[i].ordy;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ir", i), 177'(ira), 177'(tbl[i].e_ir));
         chk($sformatf("v%0d_ov", i), 177'(ova), 177'(tbl[i].e_ov));
         chk($sformatf("v%0d_occ", i), 177'(occa), 177'(tbl[i].e_occ));
         if (tbl[i].ck_od) chk($sformatf("v%0d_od", i), 177'(oda), 177'(tbl[i].e_od));
      end
      ra = 1'b1; fa = 1'b0; iva = 1'b0; ida = 8'h00; ora = 1'b0;

      // Test 5: reset in TWO with out_ready=1 on the CLEAR_DATA=0 instance.
      x1 = 177'h1_2345_6789_ABCD_EF01_2345_6789_ABCD_EF01_2345_6789;
      x2 = 177'h0_F0F0_F0F0_0F0F_0F0F_DEAD_BEEF_CAFE_F00D_1357_9BDF;
      x3 = 177'h1_FFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
      cyc_b(1'b0, 1'b0, 177'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      cyc_b(1'b0, 1'b0, 177'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      cyc_b(1'b1, 1'b0, 177'd0, 1'b0, 1'b1, 1'b0, 2'd0);
      cyc_b(1'b1, 1'b1, x1,     1'b0, 1'b1, 1'b1, 2'd1);
      chk("b_head", odb, x1);
      cyc_b(1'b1, 1'b1, x2,     1'b0, 1'b0, 1'b1, 2'd2);
      cyc_b(1'b0, 1'b1, x3,     1'b1, 1'b0, 1'b0, 2'd0);
      chk("b_retain", odb, x1);
      cyc_b(1'b1, 1'b0, 177'd0, 1'b0, 1'b1, 1'b0, 2'd0);
      chk("b_retain2", odb, x1);

      // Test 6: random valid/ready at 50% for 10k cycles, then drain.
      for (int c = 0; c < 10000; c++) begin
         step_b(1'($urandom_range(1, 0)), rnd177(), 1'($urandom_range(1, 0)));
      end
      for (int c = 0; c < 6; c++) begin
         step_b(1'b0, 177'd0, 1'b1);
      end
      chk("drain_empty", 177'(sb.size()), 177'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
